video_timing_analyzer: RTL

Receive-side counterpart of the core video timing generator. It samples an incoming pixel stream's sync and blank signals (HS/VS/HBlank/VBlank plus pixel enable) and measures the line and frame geometry. It recovers active-area pixel coordinates and declares lock once the geometry is stable over consecutive frames. It sits between any video source (core output, debug path, external capture) and consumers that need coordinates or mode detection, such as overlays, analyzers and scalers.

---
 rtl/video_timing_analyzer.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/video_timing_analyzer.sv
// video_timing_analyzer
//   Measures line/frame geometry of an incoming sync/blank pixel stream,
//   recovers active-area coordinates and declares lock once the measured
//   geometry repeats over LOCK_FRAMES consecutive frames.
// Ports
//   clk, reset_n            clock, async active-low reset
//   ce_pix                  pixel enable; all inputs sampled only when high
//   hsync/vsync             syncs, polarity HS_POL/VS_POL (0 = active-low)
//   hblank/vblank           blanks, active-high
//   h_total/h_active/h_sync_w/v_total/v_active   published geometry
//   pixel_x/pixel_y/in_active                    current-pixel coordinates
//   frame_start/mode_change one-clk pulses (vsync leading edge / new geometry)
//   locked/signal_lost      lock status, hsync timeout
module video_timing_analyzer #(
  parameter int CNT_W       = 12,
  parameter int LOCK_FRAMES = 2,
  parameter int HS_POL      = 0,
  parameter int VS_POL      = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce_pix,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             hblank,
  input  logic             vblank,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] h_sync_w,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             in_active,
  output logic             frame_start,
  output logic             mode_change,
  output logic             locked,
  output logic             signal_lost
);

  typedef enum logic [1:0] {S_WAIT, S_FIRST, S_TRACK, S_LOCK} state_t;

  localparam logic [CNT_W-1:0] CMAX    = '1;
  localparam logic [CNT_W-1:0] CMAX_M1 = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [3:0]       LF      = 4'(LOCK_FRAMES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CMAX) ? v : v + 1'b1;
  endfunction

  logic             hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, hs_cnt_q, hs_cnt_d, ha_cnt_q, ha_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d, va_cnt_q, va_cnt_d;
  logic [CNT_W-1:0] h_tot_m_q, h_tot_m_d, h_act_m_q, h_act_m_d, h_sync_m_q, h_sync_m_d;
  logic [CNT_W-1:0] h_total_q, h_total_d, h_active_q, h_active_d, h_sync_w_q, h_sync_w_d;
  logic [CNT_W-1:0] v_total_q, v_total_d, v_active_q, v_active_d;
  logic [CNT_W-1:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic             in_active_q, in_active_d, frame_start_q, frame_start_d;
  logic             mode_change_q, mode_change_d, locked_q, locked_d;
  logic             signal_lost_q, signal_lost_d;
  state_t           state_q, state_d;
  logic [3:0]       match_cnt_q, match_cnt_d, match_inc;

  logic             hs_n, vs_n, hle, hte, vle, act, timeout, same, publish;
  logic [CNT_W-1:0] v_line, va_line;

  always_comb begin
    hs_n    = (HS_POL != 0) ? hsync : ~hsync;
    vs_n    = (VS_POL != 0) ? vsync : ~vsync;
    hle     = ce_pix & hs_n & ~hs_prev_q;
    hte     = ce_pix & ~hs_n & hs_prev_q;
    vle     = ce_pix & vs_n & ~vs_prev_q;
    act     = ~hblank & ~vblank;
    // Continuous while h_cnt sits at (or is about to hit) saturation, so the
    // FSM is held in WAIT for as long as hsync stays absent.
    timeout = ce_pix & ~hle & (h_cnt_q >= CMAX_M1);
  end

  always_comb begin
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    h_cnt_d       = h_cnt_q;
    hs_cnt_d      = hs_cnt_q;
    ha_cnt_d      = ha_cnt_q;
    v_cnt_d       = v_cnt_q;
    va_cnt_d      = va_cnt_q;
    h_tot_m_d     = h_tot_m_q;
    h_act_m_d     = h_act_m_q;
    h_sync_m_d    = h_sync_m_q;
    h_total_d     = h_total_q;
    h_active_d    = h_active_q;
    h_sync_w_d    = h_sync_w_q;
    v_total_d     = v_total_q;
    v_active_d    = v_active_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    in_active_d   = in_active_q;
    frame_start_d = 1'b0;
    mode_change_d = 1'b0;
    signal_lost_d = signal_lost_q;
    state_d       = state_q;
    match_cnt_d   = match_cnt_q;
    match_inc     = match_cnt_q + 4'd1;
    publish       = 1'b0;
    // Line counts including the line that ends on this sample, so a VLE
    // landing on an HLE sees the complete frame.
    v_line        = hle ? sat_inc(v_cnt_q) : v_cnt_q;
    va_line       = (hle && ha_cnt_q != '0) ? sat_inc(va_cnt_q) : va_cnt_q;
    same          = 1'b0;

    if (ce_pix) begin
      hs_prev_d   = hs_n;
      vs_prev_d   = vs_n;
      pixel_x_d   = ha_cnt_q;
      pixel_y_d   = va_cnt_q;
      in_active_d = act;

      if (hle) begin
        h_tot_m_d = sat_inc(h_cnt_q);
        h_cnt_d   = '0;
      end else begin
        h_cnt_d   = sat_inc(h_cnt_q);
      end

      if (hte) begin
        h_sync_m_d = hs_cnt_q;
        hs_cnt_d   = '0;
      end else if (hs_n) begin
        hs_cnt_d   = sat_inc(hs_cnt_q);
      end

      if (hle) begin
        if (ha_cnt_q != '0) h_act_m_d = ha_cnt_q;
        ha_cnt_d = '0;
      end else if (act) begin
        ha_cnt_d = sat_inc(ha_cnt_q);
      end

      if (vle) begin
        v_cnt_d  = '0;
        va_cnt_d = '0;
      end else begin
        v_cnt_d  = v_line;
        va_cnt_d = va_line;
      end

      frame_start_d = vle;
      if (hle) signal_lost_d = 1'b0;

      same = (h_tot_m_d == h_total_q) && (h_act_m_d == h_active_q) &&
             (h_sync_m_d == h_sync_w_q) && (v_line == v_total_q) &&
             (va_line == v_active_q);

      if (timeout) begin
        signal_lost_d = 1'b1;
        state_d       = S_WAIT;
        match_cnt_d   = '0;
      end else if (vle) begin
        unique case (state_q)
          S_WAIT:  state_d = S_FIRST;   // partial frame, discard
          S_FIRST: begin
            publish     = 1'b1;
            match_cnt_d = '0;
            state_d     = S_TRACK;
          end
          S_TRACK: begin
            if (same) begin
              match_cnt_d = match_inc;
              if (match_inc == LF) state_d = S_LOCK;
            end else begin
              publish       = 1'b1;
              mode_change_d = 1'b1;
              match_cnt_d   = '0;
            end
          end
          S_LOCK: begin
            if (!same) begin
              publish       = 1'b1;
              mode_change_d = 1'b1;
              match_cnt_d   = '0;
              state_d       = S_TRACK;
            end
          end
          default: state_d = S_WAIT;
        endcase
      end

      if (publish) begin
        h_total_d  = h_tot_m_d;
        h_active_d = h_act_m_d;
        h_sync_w_d = h_sync_m_d;
        v_total_d  = v_line;
        v_active_d = va_line;
      end
    end

    locked_d = (state_d == S_LOCK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      h_cnt_q       <= '0;
      hs_cnt_q      <= '0;
      ha_cnt_q      <= '0;
      v_cnt_q       <= '0;
      va_cnt_q      <= '0;
      h_tot_m_q     <= '0;
      h_act_m_q     <= '0;
      h_sync_m_q    <= '0;
      h_total_q     <= '0;
      h_active_q    <= '0;
      h_sync_w_q    <= '0;
      v_total_q     <= '0;
      v_active_q    <= '0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      in_active_q   <= 1'b0;
      frame_start_q <= 1'b0;
      mode_change_q <= 1'b0;
      locked_q      <= 1'b0;
      signal_lost_q <= 1'b0;
      state_q       <= S_WAIT;
      match_cnt_q   <= '0;
    end else begin
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      h_cnt_q       <= h_cnt_d;
      hs_cnt_q      <= hs_cnt_d;
      ha_cnt_q      <= ha_cnt_d;
      v_cnt_q       <= v_cnt_d;
      va_cnt_q      <= va_cnt_d;
      h_tot_m_q     <= h_tot_m_d;
      h_act_m_q     <= h_act_m_d;
      h_sync_m_q    <= h_sync_m_d;
      h_total_q     <= h_total_d;
      h_active_q    <= h_active_d;
      h_sync_w_q    <= h_sync_w_d;
      v_total_q     <= v_total_d;
      v_active_q    <= v_active_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      in_active_q   <= in_active_d;
      frame_start_q <= frame_start_d;
      mode_change_q <= mode_change_d;
      locked_q      <= locked_d;
      signal_lost_q <= signal_lost_d;
      state_q       <= state_d;
      match_cnt_q   <= match_cnt_d;
    end
  end

  assign h_total     = h_total_q;
  assign h_active    = h_active_q;
  assign h_sync_w    = h_sync_w_q;
  assign v_total     = v_total_q;
  assign v_active    = v_active_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign in_active   = in_active_q;
  assign frame_start = frame_start_q;
  assign mode_change = mode_change_q;
  assign locked      = locked_q;
  assign signal_lost = signal_lost_q;

endmodule
